lsu_park_scheduler: RTL and testbench
=====================================

Name: lsu_park_scheduler

Overview:
- Sits between issue_read_operands handoff and the issue stage.
- When the LSU stalls, it parks LOAD/STORE scoreboard entries in a small in-order queue. Independent non-memory instructions may overtake them.
- It sequences the parked entries back out in program order once the LSU is ready, when a hazard or control-flow instruction appears, or when the bypass budget runs out.

Parameters:
- NR_PARK, 2, depth of the parking queue (≥1).
- MAX_BYPASS, 4, consecutive overtaking instructions allowed before a forced drain (≥1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush
- debug_req_i  in  1  debug request; blocks new parking
- issue_entry_i  in  scoreboard_entry_t  upstream instruction
- issue_entry_valid_i  in  1  upstream valid
- is_ctrl_flow_i  in  1  upstream is control flow
- issue_instr_ack_o  out  1  upstream entry consumed
- issue_entry_o  out  scoreboard_entry_t  instruction to issue
- issue_entry_valid_o  out  1  downstream valid
- is_ctrl_flow_o  out  1  downstream control-flow flag
- issue_instr_ack_i  in  1  issue accepted issue_entry_o
- lsu_ready_i  in  1  LSU can accept
- parked_cnt_o  out  $clog2(NR_PARK+1)  queue occupancy
- draining_o  out  1  FSM in DRAIN

Behaviour:
- Reset is rst_ni async, active-low, on clock clk_i.
  - Reset state: queue empty, bypass counter 0, FSM IDLE.
  - parked_cnt_o=0 and draining_o=0 after reset; the datapath outputs then follow pass-through.
- Memory op: fu==LOAD or fu==STORE. Control op: fu==CTRL_FLOW or is_ctrl_flow_i.
- Hazard: any valid parked entry P meets at least one of:
  - in.rs1==P.rd, or in.rs2==P.rd, or in.rd==P.rd;
  - in.rd==P.rs1, or in.rd==P.rs2.
  - Register 0 is not exempted (conservative).
- IDLE (queue empty):
  - Default is combinational pass-through: entry_o=entry_i, valid_o=valid_i, ctrl_o=ctrl_i, ack_o=ack_i.
  - Park instead when valid_i, the entry is a memory op, !lsu_ready_i and !debug_req_i.
    - On park: valid_o=0, ack_o=1, entry pushed at the tail, next state PARKED, bypass counter cleared.
- PARKED (queue non-empty, !lsu_ready_i):
  - Bypass: valid_i, non-memory, non-control, no hazard, counter<MAX_BYPASS.
    - Outputs pass through; ack_o=ack_i.
    - The counter increments on each ack_i.
  - Park: valid_i, memory op, queue not full, no hazard, !debug_req_i.
    - valid_o=0, ack_o=1, push.
  - Otherwise, with valid_i or debug_req_i or counter==MAX_BYPASS: next state DRAIN.
    - In the same cycle: present the head, ack_o=0.
  - valid_i=0 and no trigger: valid_o=0, ack_o=0, stay.
- PARKED with lsu_ready_i, and all of DRAIN:
  - Present the head: entry_o=head, valid_o=1, ctrl_o=0, ack_o=0.
  - Pop on ack_i.
  - PARKED→DRAIN on lsu_ready_i.
  - DRAIN→IDLE in the cycle the last entry pops; the counter clears then.
  - The upstream entry is held and is never consumed while in DRAIN.
- Ordering:
  - Parked entries leave strictly FIFO.
  - Parked entries never overtake one another or any older non-parked instruction.
  - The first instruction after DRAIN exits is the upstream entry.
- Queue full + memory op arriving: enter DRAIN. Never overwrite; never drop.
- Simultaneous pop and push: not possible; push occurs only when no head is presented.
- flush_i takes precedence over everything:
  - Same cycle: valid_o=0, ack_o=0.
  - Next cycle: queue empty, counter 0, IDLE.
- Reset mid-drain: all state cleared asynchronously; parked entries are discarded.
- Pointers wrap modulo NR_PARK.
- parked_cnt_o is registered occupancy.

Test Plan:
- IDLE, lsu_ready_i=1, ALU op rd=5 valid, ack_i=1 -> passes unchanged same cycle; parked_cnt_o stays 0.
- lsu_ready_i=0, LOAD rd=3 -> ack_o=1, valid_o=0; then ADD rs1=7 rd=8 -> ADD passes with valid_o=1. Raise lsu_ready_i -> LOAD issues the next cycle; FSM returns to IDLE.
- Parked LOAD rd=3, then ADD rs1=3 -> ADD is not acked; draining_o=1; LOAD is presented; after LOAD is acked, ADD passes.
- NR_PARK=2: park LOAD, STORE, then a third LOAD with lsu_ready_i=0 -> DRAIN entered; the parked entries issue in order LOAD, STORE; then the third LOAD passes.
- MAX_BYPASS=4: one parked STORE, five independent ALU ops -> four bypass, DRAIN entered before the fifth; STORE issues before the fifth.
- Two entries parked, flush_i for 1 cycle -> valid_o=0 that cycle; parked_cnt_o=0 next cycle; flushed entries never reappear.

Source files
------------

// File: rtl/lsu_park_scheduler_if.sv
// Handshake bundle between the operand-read handoff (upstream), the parking
// scheduler and the issue stage (downstream).
//
// Signals:
//   issue_entry_i / issue_entry_valid_i / is_ctrl_flow_i : upstream instruction
//   issue_instr_ack_o                                    : upstream entry consumed
//   issue_entry_o / issue_entry_valid_o / is_ctrl_flow_o : instruction to issue
//   issue_instr_ack_i                                    : issue took issue_entry_o
//
// Modports:
//   slave  : the scheduler
//   master : the surroundings (upstream producer + downstream issue)
interface lsu_park_scheduler_if;

    typedef struct packed {
        logic [1:0]  fu;   // 0 ALU, 1 LOAD, 2 STORE, 3 CTRL_FLOW
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
    } scoreboard_entry_t;

    scoreboard_entry_t issue_entry_i;
    logic              issue_entry_valid_i;
    logic              is_ctrl_flow_i;
    logic              issue_instr_ack_o;
    scoreboard_entry_t issue_entry_o;
    logic              issue_entry_valid_o;
    logic              is_ctrl_flow_o;
    logic              issue_instr_ack_i;

    modport slave (
        input  issue_entry_i, issue_entry_valid_i, is_ctrl_flow_i, issue_instr_ack_i,
        output issue_instr_ack_o, issue_entry_o, issue_entry_valid_o, is_ctrl_flow_o
    );

    modport master (
        output issue_entry_i, issue_entry_valid_i, is_ctrl_flow_i, issue_instr_ack_i,
        input  issue_instr_ack_o, issue_entry_o, issue_entry_valid_o, is_ctrl_flow_o
    );

endinterface

// File: rtl/lsu_park_scheduler.sv
// Parks LOAD/STORE entries in a small in-order queue while the LSU stalls,
// letting independent non-memory instructions overtake them, and drains the
// parked entries back out in program order.
//
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   flush_i        : pipeline flush, empties the queue
//   debug_req_i    : blocks new parking, forces a drain when entries are parked
//   lsu_ready_i    : LSU can accept a memory op
//   bus            : upstream/downstream handshake (slave side)
//   parked_cnt_o   : registered queue occupancy
//   draining_o     : scheduler is draining parked entries
module lsu_park_scheduler #(
    parameter int NR_PARK    = 2,
    parameter int MAX_BYPASS = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         debug_req_i,
    input  logic                         lsu_ready_i,
    lsu_park_scheduler_if.slave          bus,
    output logic [$clog2(NR_PARK+1)-1:0] parked_cnt_o,
    output logic                         draining_o
);

    localparam int CNT_W = $clog2(NR_PARK + 1);
    localparam int BYP_W = $clog2(MAX_BYPASS + 1);
    localparam int PTR_W = (NR_PARK > 1) ? $clog2(NR_PARK) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NR_PARK);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [BYP_W-1:0] BYP_MAX  = BYP_W'(MAX_BYPASS);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NR_PARK - 1);

    localparam logic [1:0] FU_LOAD  = 2'd1;
    localparam logic [1:0] FU_STORE = 2'd2;
    localparam logic [1:0] FU_CTRL  = 2'd3;

    // Same layout as scoreboard_entry_t in lsu_park_scheduler_if.
    typedef struct packed {
        logic [1:0]  fu;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
    } entry_t;

    typedef enum logic [1:0] {IDLE, PARKED, DRAIN} state_t;

    state_t             state, state_next;
    entry_t             slots [NR_PARK];
    logic [NR_PARK-1:0] slot_vld;
    logic [PTR_W-1:0]   head, tail;
    logic [CNT_W-1:0]   count;
    logic [BYP_W-1:0]   bypass_cnt;

    entry_t in_entry, head_entry;
    logic   in_mem, in_ctrl, hazard, full;
    logic   push, pop, byp_inc, byp_clr, present;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign in_entry   = bus.issue_entry_i;
    assign head_entry = slots[head];
    assign in_mem     = (in_entry.fu == FU_LOAD) || (in_entry.fu == FU_STORE);
    assign in_ctrl    = (in_entry.fu == FU_CTRL) || bus.is_ctrl_flow_i;
    assign full       = (count == CNT_FULL);

    // RAW, WAW and WAR against every live parked entry; x0 deliberately included.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < NR_PARK; i++) begin
            if (slot_vld[i] &&
                ((in_entry.rs1 == slots[i].rd)  || (in_entry.rs2 == slots[i].rd) ||
                 (in_entry.rd  == slots[i].rd)  || (in_entry.rd  == slots[i].rs1) ||
                 (in_entry.rd  == slots[i].rs2))) begin
                hazard = 1'b1;
            end
        end
    end

    always_comb begin
        state_next              = state;
        bus.issue_entry_o       = bus.issue_entry_i;
        bus.issue_entry_valid_o = bus.issue_entry_valid_i;
        bus.is_ctrl_flow_o      = bus.is_ctrl_flow_i;
        bus.issue_instr_ack_o   = bus.issue_instr_ack_i;
        push    = 1'b0;
        pop     = 1'b0;
        byp_inc = 1'b0;
        byp_clr = 1'b0;
        present = 1'b0;

        case (state)
            IDLE: begin
                if (bus.issue_entry_valid_i && in_mem && !lsu_ready_i && !debug_req_i) begin
                    bus.issue_entry_valid_o = 1'b0;
                    bus.issue_instr_ack_o   = 1'b1;
                    push       = 1'b1;
                    byp_clr    = 1'b1;
                    state_next = PARKED;
                end
            end
            PARKED: begin
                if (lsu_ready_i) begin
                    present = 1'b1;
                end else if (bus.issue_entry_valid_i && !in_mem && !in_ctrl && !hazard &&
                             (bypass_cnt != BYP_MAX)) begin
                    byp_inc = bus.issue_instr_ack_i;
                end else if (bus.issue_entry_valid_i && in_mem && !full && !hazard &&
                             !debug_req_i) begin
                    bus.issue_entry_valid_o = 1'b0;
                    bus.issue_instr_ack_o   = 1'b1;
                    push = 1'b1;
                end else if (bus.issue_entry_valid_i || debug_req_i ||
                             (bypass_cnt == BYP_MAX)) begin
                    present = 1'b1;
                end else begin
                    bus.issue_entry_valid_o = 1'b0;
                    bus.issue_instr_ack_o   = 1'b0;
                end
            end
            DRAIN:   present = 1'b1;
            default: state_next = IDLE;
        endcase

        // Head presentation holds the upstream entry; the last pop returns to IDLE.
        if (present) begin
            bus.issue_entry_o       = head_entry;
            bus.issue_entry_valid_o = 1'b1;
            bus.is_ctrl_flow_o      = 1'b0;
            bus.issue_instr_ack_o   = 1'b0;
            pop = bus.issue_instr_ack_i;
            if (bus.issue_instr_ack_i && (count == CNT_ONE)) begin
                state_next = IDLE;
                byp_clr    = 1'b1;
            end else begin
                state_next = DRAIN;
            end
        end

        if (flush_i) begin
            bus.issue_entry_valid_o = 1'b0;
            bus.issue_instr_ack_o   = 1'b0;
            push       = 1'b0;
            pop        = 1'b0;
            byp_inc    = 1'b0;
            byp_clr    = 1'b1;
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            slot_vld   <= '0;
            bypass_cnt <= '0;
        end else begin
            state <= state_next;
            if (flush_i) begin
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                slot_vld <= '0;
            end else begin
                // push and pop are mutually exclusive by construction
                if (push) begin
                    slot_vld[tail] <= 1'b1;
                    tail           <= ptr_next(tail);
                    count          <= count + CNT_W'(1);
                end
                if (pop) begin
                    slot_vld[head] <= 1'b0;
                    head           <= ptr_next(head);
                    count          <= count - CNT_W'(1);
                end
            end
            if (byp_clr) begin
                bypass_cnt <= '0;
            end else if (byp_inc) begin
                bypass_cnt <= bypass_cnt + BYP_W'(1);
            end
        end
    end

    // Payload storage carries no reset; slot_vld qualifies it.
    always_ff @(posedge clk_i) begin
        if (push) begin
            slots[tail] <= in_entry;
        end
    end

    assign parked_cnt_o = count;
    assign draining_o   = (state == DRAIN);

endmodule

// File: tb/tb_lsu_park_scheduler.sv
module tb_lsu_park_scheduler;

    localparam int NR_PARK    = 2;
    localparam int MAX_BYPASS = 4;

    localparam logic [1:0] ALU   = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] STORE = 2'd2;
    localparam logic [1:0] CTRL  = 2'd3;

    typedef struct packed {
        logic [1:0]  fu;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
    } ent_t;

    logic clk    = 1'b0;
    logic rst_ni = 1'b0;
    logic flush  = 1'b0;
    logic dbg    = 1'b0;
    logic lsu    = 1'b1;
    logic [$clog2(NR_PARK+1)-1:0] parked_cnt;
    logic draining;

    lsu_park_scheduler_if bus ();

    lsu_park_scheduler #(.NR_PARK(NR_PARK), .MAX_BYPASS(MAX_BYPASS)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .flush_i      (flush),
        .debug_req_i  (dbg),
        .lsu_ready_i  (lsu),
        .bus          (bus),
        .parked_cnt_o (parked_cnt),
        .draining_o   (draining)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int unsigned seq    = 1;
    int unsigned last_mem_pc = 0;
    bit          drop_in = 1'b0;

    // Reference model: the parked entries as a program-ordered queue.
    ent_t pq[$];
    bit   drain_mode = 1'b0;
    int   byp = 0;
    bit   issued[int unsigned];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_hazard(input ent_t in);
        foreach (pq[i]) begin
            if (in.rs1 == pq[i].rd || in.rs2 == pq[i].rd || in.rd == pq[i].rd ||
                in.rd == pq[i].rs1 || in.rd == pq[i].rs2) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic put(input logic [1:0] fu, input int rs1, input int rs2, input int rd,
                       input logic ctrl);
        ent_t e;
        e.fu  = fu;
        e.rs1 = 5'(rs1);
        e.rs2 = 5'(rs2);
        e.rd  = 5'(rd);
        e.pc  = seq;
        seq++;
        bus.issue_entry_i       = e;
        bus.issue_entry_valid_i = 1'b1;
        bus.is_ctrl_flow_i      = ctrl;
    endtask

    task automatic idle_in();
        bus.issue_entry_valid_i = 1'b0;
        bus.is_ctrl_flow_i      = 1'b0;
    endtask

    // One clock: check outputs against the model at the falling edge, advance the model.
    task automatic step();
        ent_t in, obs, ee;
        logic vin, acki, ev, ea, ec;
        bit   mem, ctl, hz, present, park, bypass;
        @(negedge clk);
        in   = bus.issue_entry_i;
        vin  = bus.issue_entry_valid_i;
        acki = bus.issue_instr_ack_i;
        mem  = (in.fu == LOAD) || (in.fu == STORE);
        ctl  = (in.fu == CTRL) || bus.is_ctrl_flow_i;
        hz   = model_hazard(in);
        chk("parked_cnt", 64'(parked_cnt), 64'(pq.size()));
        chk("draining", 64'(draining), 64'(drain_mode));

        present = 0; park = 0; bypass = 0;
        ev = vin; ea = acki; ee = in; ec = bus.is_ctrl_flow_i;
        if (flush) begin
            ev = 0; ea = 0;
        end else if (pq.size() == 0) begin
            if (vin && mem && !lsu && !dbg) park = 1;
        end else if (drain_mode || lsu) begin
            present = 1;
        end else if (vin && !mem && !ctl && !hz && byp < MAX_BYPASS) begin
            bypass = 1;
        end else if (vin && mem && pq.size() < NR_PARK && !hz && !dbg) begin
            park = 1;
        end else if (vin || dbg || byp == MAX_BYPASS) begin
            present = 1;
        end else begin
            ev = 0; ea = 0;
        end
        if (park) begin ev = 0; ea = 1; end
        if (present) begin ev = 1; ea = 0; ee = pq[0]; ec = 0; end

        chk("valid_o", 64'(bus.issue_entry_valid_o), 64'(ev));
        chk("ack_o", 64'(bus.issue_instr_ack_o), 64'(ea));
        if (ev) begin
            obs = bus.issue_entry_o;
            chk("entry_o", {15'd0, obs}, {15'd0, ee});
            chk("ctrl_o", 64'(bus.is_ctrl_flow_o), 64'(ec));
            if (acki) begin
                chk("dup_issue", 64'(issued.exists(obs.pc)), 64'd0);
                issued[obs.pc] = 1'b1;
                if (obs.fu == LOAD || obs.fu == STORE) begin
                    chk("mem_order", 64'(obs.pc > last_mem_pc), 64'd1);
                    last_mem_pc = obs.pc;
                end
            end
        end

        drop_in = flush || (vin && ea);
        if (flush) begin
            pq.delete();
            drain_mode = 0;
            byp = 0;
        end else if (present) begin
            if (acki) void'(pq.pop_front());
            drain_mode = (pq.size() != 0);
            if (pq.size() == 0) byp = 0;
        end else if (park) begin
            if (pq.size() == 0) byp = 0;
            pq.push_back(in);
        end else if (bypass && acki) begin
            byp++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        idle_in();
        lsu = 1'b1; dbg = 1'b0; flush = 1'b0;
        bus.issue_instr_ack_i = 1'b1;
        repeat (4) step();
    endtask

    task automatic rand_instr();
        int r;
        r = $urandom_range(0, 9);
        put((r < 4) ? ALU : (r < 6) ? LOAD : (r < 8) ? STORE : CTRL,
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            ($urandom_range(0, 9) == 0));
    endtask

    initial begin
        idle_in();
        bus.issue_entry_i     = '0;
        bus.issue_instr_ack_i = 1'b0;
        #12;
        chk("rst_parked_cnt", 64'(parked_cnt), 64'd0);
        chk("rst_draining", 64'(draining), 64'd0);
        chk("rst_valid_o", 64'(bus.issue_entry_valid_o), 64'd0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;

        // ALU op passes straight through while the LSU is ready
        bus.issue_instr_ack_i = 1'b1;
        put(ALU, 1, 2, 5, 1'b0);
        step();
        idle_in();
        step();

        // park a LOAD, let an independent ADD overtake it, then drain on lsu_ready
        lsu = 1'b0;
        put(LOAD, 1, 2, 3, 1'b0);
        step();
        put(ALU, 7, 0, 8, 1'b0);
        step();
        idle_in();
        lsu = 1'b1;
        step();
        step();
        chk("plan2_empty", 64'(parked_cnt), 64'd0);
        settle();

        // RAW hazard against the parked LOAD forces a drain before the ADD
        lsu = 1'b0;
        put(LOAD, 1, 2, 3, 1'b0);
        step();
        put(ALU, 3, 4, 9, 1'b0);
        bus.issue_instr_ack_i = 1'b0;
        step();
        chk("plan3_draining", 64'(draining), 64'd1);
        bus.issue_instr_ack_i = 1'b1;
        step();
        step();
        settle();

        // full queue plus another LOAD drains in order, then the LOAD passes
        lsu = 1'b0;
        put(LOAD, 1, 2, 3, 1'b0);
        step();
        put(STORE, 4, 5, 6, 1'b0);
        step();
        chk("plan4_full", 64'(parked_cnt), 64'd2);
        put(LOAD, 10, 11, 12, 1'b0);
        step();
        step();
        lsu = 1'b1;
        step();
        settle();

        // bypass budget: four ALU ops overtake a STORE, the fifth waits
        lsu = 1'b0;
        put(STORE, 2, 3, 1, 1'b0);
        step();
        for (int k = 0; k < 8; k++) begin
            if (drop_in) put(ALU, 4 + k % 3, 4, 10 + k % 4, 1'b0);
            step();
        end
        settle();

        // flush discards two parked entries
        lsu = 1'b0;
        put(LOAD, 1, 2, 3, 1'b0);
        step();
        put(STORE, 4, 5, 6, 1'b0);
        step();
        idle_in();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        chk("plan6_flushed", 64'(parked_cnt), 64'd0);
        settle();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) lsu = ~lsu;
            dbg   = ($urandom_range(0, 19) == 0);
            flush = ($urandom_range(0, 59) == 0);
            bus.issue_instr_ack_i = ($urandom_range(0, 9) < 7);
            if (!bus.issue_entry_valid_i || drop_in) begin
                if ($urandom_range(0, 9) < 8) rand_instr();
                else idle_in();
            end
            step();
        end
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
